// File: rtl/matrix_op_scheduler.sv
// Round-robin scheduler that shares the 4x4 matrix add and subtract engines
// among NUM_REQ requesters, one request in flight, result tagged with requester id.
module matrix_op_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0][1:0]              req_op,
  input  logic [NUM_REQ-1:0][3:0][3:0][7:0]    req_a,
  input  logic [NUM_REQ-1:0][3:0][3:0][7:0]    req_b,
  output logic [3:0][3:0][7:0]                 eng_a,
  output logic [3:0][3:0][7:0]                 eng_b,
  output logic                                 add_start,
  input  logic                                 add_done,
  input  logic [3:0][3:0][15:0]                add_c,
  output logic                                 sub_start,
  input  logic                                 sub_done,
  input  logic [3:0][3:0][15:0]                sub_c,
  output logic                                 resp_valid,
  input  logic                                 resp_ready,
  output logic [ID_W-1:0]                      resp_id,
  output logic [3:0][3:0][15:0]                resp_c,
  output logic [1:0]                           resp_err,
  output logic [1:0]                           dbg_state,
  output logic [ID_W-1:0]                      dbg_rr_ptr
);

  // Handshakes: a request transfers on a cycle where req_valid[i] & req_ready[i];
  // a response transfers on a cycle where resp_valid & resp_ready, and resp_*
  // stay stable while resp_valid is high. Engine start/done is a level handshake.

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, RESP} state_t;

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [ID_W:0]    NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_OP  = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic              op_is_sub;
  logic [CNT_W-1:0]  tmo_cnt;

  logic              grant_any;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W:0]     cand;
  logic              sel_done;
  logic [3:0][3:0][15:0] sel_c;

  assign dbg_state  = state;
  assign dbg_rr_ptr = rr_ptr;

  // First valid requester at or after rr_ptr, searching cyclically.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!grant_any && req_valid[cand[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_any) req_ready[grant_id] = 1'b1;
  end

  // Only legal ops reach ISSUE/RELEASE, so bit 0 of the op selects the engine.
  assign sel_done = op_is_sub ? sub_done : add_done;
  assign sel_c    = op_is_sub ? sub_c    : add_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      op_is_sub  <= 1'b0;
      tmo_cnt    <= '0;
      eng_a      <= '0;
      eng_b      <= '0;
      add_start  <= 1'b0;
      sub_start  <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_c     <= '0;
      resp_err   <= ERR_OK;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            eng_a     <= req_a[grant_id];
            eng_b     <= req_b[grant_id];
            op_is_sub <= req_op[grant_id][0];
            resp_id   <= grant_id;
            rr_ptr    <= (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
            tmo_cnt   <= '0;
            if (req_op[grant_id][1]) begin
              resp_c     <= '0;
              resp_err   <= ERR_OP;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              add_start <= ~req_op[grant_id][0];
              sub_start <= req_op[grant_id][0];
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (sel_done) begin
            resp_c    <= sel_c;
            resp_err  <= ERR_OK;
            add_start <= 1'b0;
            sub_start <= 1'b0;
            state     <= RELEASE;
          end else if (tmo_cnt == LAST_CNT) begin
            resp_c    <= '0;
            resp_err  <= ERR_TMO;
            add_start <= 1'b0;
            sub_start <= 1'b0;
            state     <= RELEASE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          // The engine must drop done before the next request can start it again.
          if (!sel_done) begin
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_op_scheduler.sv
// Bench for matrix_op_scheduler: behavioural engine stubs, a round-robin/response
// reference model with an expected queue, and directed plus randomized scenarios.
module tb_matrix_op_scheduler;

  localparam int N       = 4;
  localparam int TIMEOUT = 64;
  localparam int ID_W    = $clog2(N);
  localparam int EXP_W   = ID_W + 2 + 256;

  typedef logic [3:0][3:0][7:0]  mat8_t;
  typedef logic [3:0][3:0][15:0] mat16_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0]         req_ready;
  logic [N-1:0][1:0]    req_op = '0;
  logic [N-1:0][3:0][3:0][7:0] req_a = '0;
  logic [N-1:0][3:0][3:0][7:0] req_b = '0;
  mat8_t                eng_a, eng_b;
  logic                 add_start, add_done, sub_start, sub_done;
  mat16_t               add_c, sub_c;
  logic                 resp_valid;
  logic                 resp_ready = 1'b0;
  logic [ID_W-1:0]      resp_id;
  mat16_t               resp_c;
  logic [1:0]           resp_err;
  logic [1:0]           dbg_state;
  logic [ID_W-1:0]      dbg_rr_ptr;

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr    = 0;
  logic [EXP_W-1:0] exp_q[$];

  matrix_op_scheduler #(.NUM_REQ(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .eng_a(eng_a), .eng_b(eng_b),
    .add_start(add_start), .add_done(add_done), .add_c(add_c),
    .sub_start(sub_start), .sub_done(sub_done), .sub_c(sub_c),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_c(resp_c), .resp_err(resp_err),
    .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- engine stubs ----------------
  int   add_lat = 17, sub_lat = 17;
  bit   hang = 1'b0;   // engines never raise done
  bit   rogue = 1'b0;  // idle sub engine shows done with junk data
  int   add_cnt = 0, sub_cnt = 0;
  logic add_done_r = 1'b0, sub_done_r = 1'b0;
  int   add_cyc = 0, sub_cyc = 0;

  always @(posedge clk) begin
    if (!add_start) begin
      add_cnt <= 0; add_done_r <= 1'b0;
    end else if (add_cnt < add_lat - 1) add_cnt <= add_cnt + 1;
    else if (!hang) add_done_r <= 1'b1;
    if (!sub_start) begin
      sub_cnt <= 0; sub_done_r <= 1'b0;
    end else if (sub_cnt < sub_lat - 1) sub_cnt <= sub_cnt + 1;
    else if (!hang) sub_done_r <= 1'b1;
    if (add_start) add_cyc <= add_cyc + 1;
    if (sub_start) sub_cyc <= sub_cyc + 1;
  end

  assign add_done = add_done_r;
  assign sub_done = sub_done_r | rogue;

  always_comb begin
    add_c = '0;
    sub_c = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        add_c[i][j] = {8'h00, eng_a[i][j]} + {8'h00, eng_b[i][j]};
        sub_c[i][j] = rogue ? 16'hDEAD : ({8'h00, eng_a[i][j]} - {8'h00, eng_b[i][j]});
      end
  end

  // ---------------- reference model ----------------
  function automatic int model_grant(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++)
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [EXP_W-1:0] model_resp(input int id, input logic [1:0] op,
                                                  input mat8_t a, input mat8_t b, input bit hung);
    mat16_t c = '0;
    logic [1:0] e;
    if (op >= 2'd2) e = 2'b01;
    else if (hung) e = 2'b10;
    else begin
      e = 2'b00;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          c[i][j] = (op == 2'd0) ? 16'(int'(a[i][j]) + int'(b[i][j]))
                                 : 16'(int'(a[i][j]) - int'(b[i][j]));
    end
    return {ID_W'(id), e, c};
  endfunction

  function automatic mat8_t fill_mat(input logic [7:0] v);
    mat8_t m;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m[i][j] = v;
    return m;
  endfunction

  function automatic mat8_t rand_mat();
    mat8_t m;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m[i][j] = 8'($urandom);
    return m;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge with valids driven; returns just after the accepting posedge.
  task automatic wait_accept(output logic [N-1:0] grant, output bit got);
    got = 1'b0;
    grant = '0;
    #1;
    for (int k = 0; k < 100; k++) begin
      if (req_ready !== '0) begin
        grant = req_ready;
        got = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    if (got) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic issue_req(input int id, input logic [1:0] op, input mat8_t a, input mat8_t b,
                           output logic [N-1:0] grant, output bit got);
    req_op[id] = op;
    req_a[id]  = a;
    req_b[id]  = b;
    req_valid  = '0;
    req_valid[id] = 1'b1;
    wait_accept(grant, got);
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic get_resp(input int delay, output logic [ID_W-1:0] id, output mat16_t c,
                          output logic [1:0] err, output bit got, output int wait_cyc,
                          output bit stable, output bit quiet);
    got = 1'b0; stable = 1'b1; quiet = 1'b1; wait_cyc = 0;
    id = '0; c = '0; err = '0;
    for (int k = 0; k < 200; k++) begin
      if (resp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      if (req_ready !== '0) quiet = 1'b0;
      @(negedge clk);
      wait_cyc++;
    end
    if (!got) return;
    id = resp_id; c = resp_c; err = resp_err;
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_id !== id || resp_c !== c || resp_err !== err) stable = 1'b0;
      if (req_ready !== '0) quiet = 1'b0;
    end
    resp_ready = 1'b1;
    if (req_ready !== '0) quiet = 1'b0;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    if (resp_valid !== 1'b0) stable = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0 (IDLE)", dbg_state); end
    n_checks++; if (dbg_rr_ptr !== '0) begin n_fail++; $display("FAIL reset_rr_ptr: got %0d want 0", dbg_rr_ptr); end
    n_checks++; if ({add_start, sub_start, resp_valid} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b want 000", {add_start, sub_start, resp_valid}); end
    n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_checks++; if ({resp_id, resp_err, resp_c} !== '0) begin n_fail++; $display("FAIL reset_resp: got %h want 0", {resp_id, resp_err, resp_c}); end
    n_checks++; if ({eng_a, eng_b} !== '0) begin n_fail++; $display("FAIL reset_eng: got %h want 0", {eng_a, eng_b}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Single request from one requester, checked against the model end to end.
  task automatic run_single(input string name, input int id, input logic [1:0] op,
                            input mat8_t a, input mat8_t b, input bit hung,
                            output int add_d, output int sub_d, output int wait_cyc);
    logic [N-1:0] grant; bit got, rgot, stable, quiet;
    logic [ID_W-1:0] rid; mat16_t rc; logic [1:0] rerr;
    logic [EXP_W-1:0] exp_v;
    int a0, s0, exp_id;
    a0 = add_cyc; s0 = sub_cyc;
    exp_id = model_grant(N'(1) << id, m_ptr);
    issue_req(id, op, a, b, grant, got);
    n_checks++; if (!got || grant !== (N'(1) << exp_id)) begin n_fail++; $display("FAIL %s_grant: got %b want %b", name, grant, N'(1) << exp_id); end
    m_ptr = (exp_id + 1) % N;
    exp_q.push_back(model_resp(exp_id, op, a, b, hung));
    get_resp($urandom_range(0, 3), rid, rc, rerr, rgot, wait_cyc, stable, quiet);
    exp_v = exp_q.pop_front();
    n_checks++; if (!rgot || {rid, rerr, rc} !== exp_v) begin n_fail++; $display("FAIL %s_resp: got %h want %h", name, {rid, rerr, rc}, exp_v); end
    n_checks++; if (!stable || !quiet) begin n_fail++; $display("FAIL %s_hold: stable %0d quiet %0d want 1 1", name, stable, quiet); end
    n_checks++; if (eng_a !== a || eng_b !== b) begin n_fail++; $display("FAIL %s_eng_operands: got %h want %h", name, {eng_a, eng_b}, {a, b}); end
    add_d = add_cyc - a0;
    sub_d = sub_cyc - s0;
  endtask

  task automatic test_add();
    int ad, sd, w;
    run_single("add", 0, 2'd0, fill_mat(8'd5), fill_mat(8'd3), 1'b0, ad, sd, w);
    n_checks++; if (ad == 0 || sd != 0) begin n_fail++; $display("FAIL add_starts: add %0d sub %0d cycles want >0 and 0", ad, sd); end
  endtask

  task automatic test_sub();
    int ad, sd, w;
    run_single("sub", 1, 2'd1, fill_mat(8'd3), fill_mat(8'd5), 1'b0, ad, sd, w);
    n_checks++; if (sd == 0 || ad != 0) begin n_fail++; $display("FAIL sub_starts: add %0d sub %0d cycles want 0 and >0", ad, sd); end
  endtask

  task automatic test_illegal_op();
    int ad, sd, w;
    run_single("illegal", 2, 2'd3, rand_mat(), rand_mat(), 1'b0, ad, sd, w);
    n_checks++; if (ad != 0 || sd != 0) begin n_fail++; $display("FAIL illegal_starts: add %0d sub %0d cycles want 0 0", ad, sd); end
    n_checks++; if (w > 2) begin n_fail++; $display("FAIL illegal_latency: %0d cycles want <=2", w); end
  endtask

  task automatic test_timeout();
    int ad, sd, w;
    hang = 1'b1;
    run_single("timeout", 0, 2'd0, rand_mat(), rand_mat(), 1'b1, ad, sd, w);
    hang = 1'b0;
    n_checks++; if (ad != TIMEOUT || sd != 0) begin n_fail++; $display("FAIL timeout_start_len: add %0d sub %0d want %0d 0", ad, sd, TIMEOUT); end
    n_checks++; if (dbg_rr_ptr !== ID_W'(m_ptr)) begin n_fail++; $display("FAIL timeout_rr_ptr: got %0d want %0d", dbg_rr_ptr, m_ptr); end
  endtask

  task automatic test_ignore_other();
    int ad, sd, w;
    rogue = 1'b1;
    run_single("ignore_other", 2, 2'd0, rand_mat(), rand_mat(), 1'b0, ad, sd, w);
    rogue = 1'b0;
    n_checks++; if (sd != 0) begin n_fail++; $display("FAIL ignore_other_sub_start: %0d cycles want 0", sd); end
  endtask

  task automatic test_reset_mid_op();
    logic [N-1:0] grant; bit got, seen;
    issue_req(1, 2'd0, rand_mat(), rand_mat(), grant, got);
    repeat (5) @(negedge clk);
    n_checks++; if (!got || add_start !== 1'b1) begin n_fail++; $display("FAIL midrst_issue: got %0d add_start %b want 1 1", got, add_start); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (add_start !== 1'b0 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_async: add_start %b resp_valid %b want 0 0", add_start, resp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    exp_q.delete();
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || add_start !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL midrst_discard: stale activity seen want none"); end
  endtask

  // All requesters valid continuously; grants must rotate 0,1,2,3,0.
  task automatic test_back_to_back();
    mat8_t cur_a[N], cur_b[N];
    logic [N-1:0] grant; bit got, rgot, stable, quiet;
    logic [ID_W-1:0] rid; mat16_t rc; logic [1:0] rerr;
    logic [EXP_W-1:0] exp_v;
    int exp_id, w;
    for (int i = 0; i < N; i++) begin
      cur_a[i] = rand_mat(); cur_b[i] = rand_mat();
      req_a[i] = cur_a[i]; req_b[i] = cur_b[i]; req_op[i] = 2'd0;
    end
    req_valid = '1;
    for (int t = 0; t < 5; t++) begin
      exp_id = model_grant('1, m_ptr);
      wait_accept(grant, got);
      n_checks++; if (!got || grant !== (N'(1) << exp_id) || exp_id != t % N) begin n_fail++; $display("FAIL b2b_grant%0d: got %b want %b", t, grant, N'(1) << (t % N)); end
      exp_q.push_back(model_resp(exp_id, 2'd0, cur_a[exp_id], cur_b[exp_id], 1'b0));
      m_ptr = (exp_id + 1) % N;
      cur_a[exp_id] = rand_mat(); cur_b[exp_id] = rand_mat();
      req_a[exp_id] = cur_a[exp_id]; req_b[exp_id] = cur_b[exp_id];
      @(negedge clk);
      get_resp($urandom_range(0, 2), rid, rc, rerr, rgot, w, stable, quiet);
      exp_v = exp_q.pop_front();
      n_checks++; if (!rgot || {rid, rerr, rc} !== exp_v) begin n_fail++; $display("FAIL b2b_resp%0d: got %h want %h", t, {rid, rerr, rc}, exp_v); end
      n_checks++; if (!stable || !quiet) begin n_fail++; $display("FAIL b2b_hold%0d: stable %0d quiet %0d want 1 1", t, stable, quiet); end
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_random();
    mat8_t cur_a[N], cur_b[N];
    logic [1:0] cur_op[N];
    logic [N-1:0] mask, grant; bit got, rgot, stable, quiet;
    logic [ID_W-1:0] rid; mat16_t rc; logic [1:0] rerr;
    logic [EXP_W-1:0] exp_v;
    int exp_id, w, r;
    for (int t = 0; t < 25; t++) begin
      add_lat = $urandom_range(2, 20);
      sub_lat = $urandom_range(2, 20);
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 9);
        cur_op[i] = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
        cur_a[i] = rand_mat(); cur_b[i] = rand_mat();
        req_op[i] = cur_op[i]; req_a[i] = cur_a[i]; req_b[i] = cur_b[i];
      end
      req_valid = mask;
      exp_id = model_grant(mask, m_ptr);
      wait_accept(grant, got);
      req_valid = '0;
      n_checks++; if (!got || grant !== (N'(1) << exp_id)) begin n_fail++; $display("FAIL rand_grant%0d: got %b want %b", t, grant, N'(1) << exp_id); end
      exp_q.push_back(model_resp(exp_id, cur_op[exp_id], cur_a[exp_id], cur_b[exp_id], 1'b0));
      m_ptr = (exp_id + 1) % N;
      @(negedge clk);
      get_resp($urandom_range(0, 3), rid, rc, rerr, rgot, w, stable, quiet);
      exp_v = exp_q.pop_front();
      n_checks++; if (!rgot || {rid, rerr, rc} !== exp_v) begin n_fail++; $display("FAIL rand_resp%0d: got %h want %h", t, {rid, rerr, rc}, exp_v); end
      n_checks++; if (!stable || !quiet) begin n_fail++; $display("FAIL rand_hold%0d: stable %0d quiet %0d want 1 1", t, stable, quiet); end
    end
    add_lat = 17;
    sub_lat = 17;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_add();
    test_sub();
    test_illegal_op();
    test_timeout();
    test_ignore_other();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
